uart_receiver: RTL

//  Host->FPGA serial receiver: the on-chip endpoint driven by the host on serial_in.

---
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 serial receiver: synchronises serial_in, samples mid-bit and presents each byte
// on a valid/ready port, with framing-error and overrun pulses.
module uart_receiver #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic [2:0] state_dbg
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Output port handshake: a byte transfers on any posedge where
    // data_out_valid and data_out_ready are both 1; data_out is held until then.

    logic          rx_meta;
    logic          rx_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          deliver_pend;
    logic          deliver_nxt;
    logic          ferr_nxt;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            deliver_pend <= 1'b0;
        end else begin
            state        <= state_nxt;
            clk_cnt      <= clk_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift        <= shift_nxt;
            deliver_pend <= deliver_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        deliver_nxt = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt == SAMPLE_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_cnt == SYMBOL_LAST) begin
                    shift_nxt[bit_cnt] = rx_s;
                    clk_cnt_nxt        = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (clk_cnt == SYMBOL_LAST) begin
                    clk_cnt_nxt = '0;
                    if (rx_s) begin
                        deliver_nxt = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before a new start bit counts.
                clk_cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clk_cnt_nxt = '0;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            frame_error    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            frame_error <= ferr_nxt;
            overrun     <= 1'b0;
            if (deliver_pend) begin
                // An unaccepted byte wins; a byte accepted this cycle is replaced.
                if (data_out_valid && !data_out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    data_out       <= shift;
                    data_out_valid <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule
